// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - first-word-fall-through synchronous FIFO with any DEPTH,
// a fill counter, level flags, sticky error flags and synchronous flush.
module fifo_sync_flags #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 7,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int SW          = $clog2(DEPTH + 1),
  localparam int PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             setData_i,
  input  logic             getData_i,
  input  logic             flush_i,
  input  logic             clearErr_i,
  output logic [WIDTH-1:0] data_o,
  output logic [SW-1:0]    size_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almostFull_o,
  output logic             almostEmpty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;
  logic             ovf_ev;
  logic             udf_ev;

  assign full_o        = (size_o == SW'(DEPTH));
  assign empty_o       = (size_o == '0);
  assign almostFull_o  = (size_o >= SW'(AFULL_LEVEL));
  assign almostEmpty_o = (size_o <= SW'(AEMPTY_LEVEL));
  assign data_o        = empty_o ? '0 : mem[rd_ptr];

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_ok  = getData_i && !flush_i && !empty_o;
  assign wr_ok  = setData_i && !flush_i && (!full_o || rd_ok);
  assign ovf_ev = setData_i && !flush_i && full_o && !rd_ok;
  assign udf_ev = getData_i && !flush_i && empty_o;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (wr_ok && !rst_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      size_o <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      size_o <= '0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   size_o <= size_o + SW'(1);
        2'b01:   size_o <= size_o - SW'(1);
        default: size_o <= size_o;
      endcase
    end
  end

  // An error event in the same cycle as clearErr_i leaves the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (ovf_ev)          overflow_o <= 1'b1;
      else if (clearErr_i) overflow_o <= 1'b0;
      if (udf_ev)          underflow_o <= 1'b1;
      else if (clearErr_i) underflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - randomized and directed bench for fifo_sync_flags
// against a queue-based model, on a DEPTH=7 and a DEPTH=5 instance.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       set = 1'b0;
  logic       get = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] d7_data, d5_data;
  logic [2:0] d7_size, d5_size;
  logic d7_full, d7_empty, d7_af, d7_ae, d7_ovf, d7_udf;
  logic d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_udf;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WIDTH(8), .DEPTH(7)) d7 (
    .clk_i(clk), .rst_i(rst), .data_i(din), .setData_i(set), .getData_i(get),
    .flush_i(flush), .clearErr_i(clr), .data_o(d7_data), .size_o(d7_size),
    .full_o(d7_full), .empty_o(d7_empty), .almostFull_o(d7_af),
    .almostEmpty_o(d7_ae), .overflow_o(d7_ovf), .underflow_o(d7_udf));

  fifo_sync_flags #(.WIDTH(8), .DEPTH(5), .AFULL_LEVEL(3), .AEMPTY_LEVEL(2)) d5 (
    .clk_i(clk), .rst_i(rst), .data_i(din), .setData_i(set), .getData_i(get),
    .flush_i(flush), .clearErr_i(clr), .data_o(d5_data), .size_o(d5_size),
    .full_o(d5_full), .empty_o(d5_empty), .almostFull_o(d5_af),
    .almostEmpty_o(d5_ae), .overflow_o(d5_ovf), .underflow_o(d5_udf));

  // Reference model: one queue of stored words per instance, oldest at index 0.
  logic [7:0] mq [2][$];
  bit m_ovf [2];
  bit m_udf [2];
  int m_depth [2] = '{7, 5};
  int m_afl [2]   = '{6, 3};
  int m_ael [2]   = '{1, 2};
  int m_n;
  bit m_rd, m_wr;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_n = mq[i].size();
      if (rst) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_udf[i] = 1'b0;
      end else if (flush) begin
        mq[i].delete();
        if (clr) begin
          m_ovf[i] = 1'b0;
          m_udf[i] = 1'b0;
        end
      end else begin
        m_rd = get && (m_n > 0);
        m_wr = set && (m_n < m_depth[i] || m_rd);
        if (m_rd) void'(mq[i].pop_front());
        if (m_wr) mq[i].push_back(din);
        if (set && !m_wr) m_ovf[i] = 1'b1;
        else if (clr)     m_ovf[i] = 1'b0;
        if (get && m_n == 0) m_udf[i] = 1'b1;
        else if (clr)        m_udf[i] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input int size, input int data, input bit full,
                          input bit empty, input bit af, input bit ae, input bit ovf,
                          input bit udf);
    int n;
    string p;
    n = mq[i].size();
    p = $sformatf("d%0d", m_depth[i]);
    check({p, ".size"}, size, n);
    check({p, ".data"}, data, (n > 0) ? int'(mq[i][0]) : 0);
    check({p, ".full"}, int'(full), int'(n == m_depth[i]));
    check({p, ".empty"}, int'(empty), int'(n == 0));
    check({p, ".afull"}, int'(af), int'(n >= m_afl[i]));
    check({p, ".aempty"}, int'(ae), int'(n <= m_ael[i]));
    check({p, ".ovf"}, int'(ovf), int'(m_ovf[i]));
    check({p, ".udf"}, int'(udf), int'(m_udf[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, int'(d7_size), int'(d7_data), d7_full, d7_empty, d7_af, d7_ae, d7_ovf, d7_udf);
      cmp_inst(1, int'(d5_size), int'(d5_data), d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_udf);
    end
  end

  task automatic step(input bit s, input bit g, input logic [7:0] d = 8'h00,
                      input bit f = 1'b0, input bit c = 1'b0, input bit r = 1'b0);
    set = s; get = g; din = d; flush = f; clr = c; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] drain_exp [7] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h20};
  int ph, rv;

  initial begin
    step(0, 0, 8'h00, 0, 0, 1);
    chk_en = 1'b1;
    step(0, 0, 8'h00, 0, 0, 1);
    check("rst.size", int'(d7_size), 0);
    check("rst.empty", int'(d7_empty), 1);
    check("rst.full", int'(d7_full), 0);
    check("rst.aempty", int'(d7_ae), 1);
    check("rst.afull", int'(d7_af), 0);
    check("rst.data", int'(d7_data), 8'h00);
    check("rst.ovf", int'(d7_ovf), 0);
    check("rst.udf", int'(d7_udf), 0);

    step(1, 0, 8'hA1);
    check("fwft.data", int'(d7_data), 8'hA1);
    check("fwft.size1", int'(d7_size), 1);
    step(1, 0, 8'hA2);
    check("fwft.size2", int'(d7_size), 2);
    step(1, 0, 8'hA3);
    check("fwft.size3", int'(d7_size), 3);
    check("rd1.data", int'(d7_data), 8'hA1);
    step(0, 1);
    check("rd2.data", int'(d7_data), 8'hA2);
    check("rd.size2", int'(d7_size), 2);
    step(0, 1);
    check("rd3.data", int'(d7_data), 8'hA3);
    step(0, 1);
    check("rd.size0", int'(d7_size), 0);
    check("rd.data0", int'(d7_data), 0);

    for (int k = 0; k < 7; k++) begin
      step(1, 0, 8'h10 + 8'(k));
      if (k == 5) begin
        check("fill6.afull", int'(d7_af), 1);
        check("fill6.full", int'(d7_full), 0);
      end
    end
    check("fill7.full", int'(d7_full), 1);
    step(1, 0, 8'hFF);
    check("ovf.flag", int'(d7_ovf), 1);
    check("ovf.size", int'(d7_size), 7);
    check("ovf.data", int'(d7_data), 8'h10);
    step(0, 0, 8'h00, 0, 1);
    check("ovf.clear", int'(d7_ovf), 0);

    step(1, 1, 8'h20);
    check("fullrw.size", int'(d7_size), 7);
    check("fullrw.ovf", int'(d7_ovf), 0);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("drain%0d", k), int'(d7_data), int'(drain_exp[k]));
      step(0, 1);
    end
    check("drain.empty", int'(d7_empty), 1);

    step(1, 1, 8'h55);
    check("udf.flag", int'(d7_udf), 1);
    check("udf.size", int'(d7_size), 1);
    check("udf.data", int'(d7_data), 8'h55);
    step(0, 1);
    step(0, 1, 8'h00, 0, 1);
    check("udf.setwins", int'(d7_udf), 1);
    step(0, 0, 8'h00, 0, 1);
    check("udf.clear", int'(d7_udf), 0);

    step(0, 0, 8'h00, 1);
    for (int k = 0; k < 12; k++) begin
      step(1, 0, 8'h30 + 8'(k));
      check($sformatf("wrap%0d", k), int'(d5_data), 8'h30 + k);
      step(0, 1);
    end
    check("wrap.empty", int'(d5_empty), 1);

    step(1, 0, 8'h40);
    step(1, 0, 8'h41);
    step(1, 0, 8'h42);
    check("pref.size", int'(d5_size), 3);
    step(1, 0, 8'h77, 1);
    check("flush.size", int'(d5_size), 0);
    check("flush.empty", int'(d5_empty), 1);
    step(0, 0);
    check("flush.nowr", int'(d5_size), 0);

    step(1, 0, 8'h50);
    step(1, 0, 8'h51);
    step(1, 1, 8'h52, 0, 0, 1);
    check("midrst.size", int'(d7_size), 0);
    check("midrst.empty", int'(d7_empty), 1);
    check("midrst.data", int'(d7_data), 0);

    for (int c = 0; c < 3000; c++) begin
      ph = (c / 150) % 3;
      rv = int'($urandom_range(0, 99));
      set = (ph == 0) ? (rv < 80) : (ph == 1) ? (rv < 25) : (rv < 50);
      rv = int'($urandom_range(0, 99));
      get = (ph == 0) ? (rv < 25) : (ph == 1) ? (rv < 80) : (rv < 50);
      din = 8'($urandom);
      flush = ($urandom_range(0, 99) < 2);
      clr = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 199) < 1);
      @(posedge clk);
      @(negedge clk);
    end

    step(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Synchronous first-word-fall-through FIFO with circular read/write pointers. Any DEPTH is allowed, including values that are not a power of two. It adds a correctly sized fill counter, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush. Drop-in buffer between UART/SPI-style byte producers and consumers in the peripheral datapath.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 7, number of storage entries (>=2, need not be a power of two)
AFULL_LEVEL, DEPTH-1, almostFull_o asserts when size_o >= this value (1..DEPTH)
AEMPTY_LEVEL, 1, almostEmpty_o asserts when size_o <= this value (0..DEPTH-1)

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_i  in  1  synchronous, active-high reset
data_i  in  WIDTH  write data
setData_i  in  1  write request
getData_i  in  1  read request (pops the word currently on data_o)
flush_i  in  1  synchronous discard of all contents
clearErr_i  in  1  clears the sticky error flags
data_o  out  WIDTH  oldest stored word; all-zero when empty
size_o  out  $clog2(DEPTH+1)  number of stored words, 0..DEPTH
full_o  out  1  size_o == DEPTH
empty_o  out  1  size_o == 0
almostFull_o  out  1  size_o >= AFULL_LEVEL
almostEmpty_o  out  1  size_o <= AEMPTY_LEVEL
overflow_o  out  1  sticky: a write was dropped
underflow_o  out  1  sticky: a read hit an empty FIFO

Behaviour:
- Reset is synchronous, active-high, sampled on the rising edge of clk_i, and has top priority. On reset: write pointer, read pointer and size_o are 0; overflow_o and underflow_o are 0. Outputs after reset: empty_o=1, full_o=0, almostEmpty_o=1 (AEMPTY_LEVEL>=0), almostFull_o=0, data_o=0. Storage array is not reset.
- Pointers run 0..DEPTH-1 and wrap to 0 by explicit compare against DEPTH-1 (no power-of-two masking).
- Write accepted when setData_i=1 and (not full, or full with an accepted read in the same cycle). Accepted write stores data_i at the write pointer and advances it.
- Read accepted when getData_i=1 and not empty. Accepted read advances the read pointer.
- First-word fall-through:
  - data_o = mem[read pointer], combinational from registered state, whenever size_o>0.
  - A word written into an empty FIFO appears on data_o the cycle after the write edge; there is no same-cycle bypass.
- size_o update: +1 for write only, -1 for read only, unchanged for both or neither. All flags decode combinationally from size_o, so they change in the same cycle as size_o.
- Boundary cases:
  - Full + set + get: both accepted, size stays DEPTH, no overflow.
  - Full + set only: data dropped, pointers and size unchanged, overflow_o <= 1.
  - Empty + get (with or without set): read rejected, underflow_o <= 1. A concurrent set is still accepted, giving size 1 next cycle.
  - Wrap-around: DEPTH consecutive write/read pairs return data in order across the wrap point.
- Flush: flush_i=1 (reset not active) sets both pointers and size_o to 0. set/get in the same cycle are ignored and raise no error flags. Sticky flags are unaffected by flush.
- Error flags:
  - Set on their event and held until clearErr_i or reset.
  - If an error event and clearErr_i occur in the same cycle, the flag ends 1 (set wins).
- Reset asserted mid-stream discards all contents; the next cycle shows the reset state regardless of set/get.
- No other state exists; the block is fully sequential with no combinational input-to-output paths.

Test Plan:
- Reset with DEPTH=7, WIDTH=8 -> size_o=0, empty_o=1, full_o=0, almostEmpty_o=1, almostFull_o=0, data_o=8'h00, overflow_o=0, underflow_o=0.
- Write 8'hA1, 8'hA2, 8'hA3, then read three times -> data_o shows A1 one cycle after the first write; reads return A1, A2, A3; size_o goes 1,2,3,2,1,0.
- Write 7 words 8'h10..8'h16, then write 8'hFF -> full_o=1 and almostFull_o=1 at size 6; 8'hFF dropped, overflow_o=1, size_o stays 7. clearErr_i -> overflow_o=0.
- Full FIFO, set+get with 8'h20 -> 8'h10 popped, size_o stays 7, no overflow. Drain returns 11..16 then 20.
- Empty FIFO, set(8'h55)+get in one cycle -> underflow_o=1, size_o=1, data_o=8'h55 next cycle. Same-cycle get+clearErr_i on empty -> underflow_o stays 1.
- DEPTH=5: 12 write/read pairs of an incrementing pattern -> data in order across wrap. Flush at size 3 with set asserted -> size_o=0, empty_o=1, write ignored. Reset mid-burst -> reset state next cycle.
